sw_step_iface: RTL and testbench
================================

Name: sw_step_iface

Overview:
- Parametrised successor to the board switch/key input interface that feeds the datapath.
- Debounces a push-button into a single-cycle step pulse. Captures control switches or data bytes only on that step, never on every clock.
- Assembles a DATA_W-bit datapath input from successive LANE_W-bit switch entries using a wrapping lane pointer.
- Sits between the DE1-SoC switches/keys and the datapath. step_out can drive a datapath clock enable.

Parameters:
- DATA_W, 16, width of assembled data word. Must be a multiple of LANE_W.
- LANE_W, 8, bits entered per step in data mode. Must be <= CTRL_W.
- CTRL_W, 9, width of captured control word. Switch bus width is CTRL_W+1.
- DEB_CYCLES, 50000, consecutive stable cycles required to accept a key level change. Must be >= 2.
- Derived: LANES = DATA_W/LANE_W. LIW = max(1, clog2(LANES)).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- key_n  in  1  raw push-button, 0 = pressed, asynchronous
- sw  in  CTRL_W+1  raw switches, asynchronous. sw[CTRL_W] = mode (1 = data entry, 0 = control entry)
- step_out  out  1  one-cycle pulse per accepted press
- data_out  out  DATA_W  assembled datapath input word
- ctrl_out  out  CTRL_W  captured control word
- lane_idx  out  LIW  lane written by the next data-mode press
- led_out  out  CTRL_W  status display

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, reset_n.
- Reset (reset_n=0 at an edge):
  - data_out=0, ctrl_out=0, lane_idx=0, step_out=0.
  - Debounce counter=0, stable key state=1 (released).
  - key synchroniser=1, sw synchroniser=0.
  - Reset mid-debounce discards the partial count. A key still held after reset is treated as a fresh press.
- Synchronisers:
  - key_n and sw each pass through a 2-stage FF synchroniser.
  - All logic uses synced values (ks, ss). mode = ss[CTRL_W].
- Debounce:
  - If ks == stable, counter clears to 0.
  - If ks != stable, counter increments. On the edge where counter == DEB_CYCLES-1 and ks != stable, stable <= ks and counter <= 0.
  - Glitches shorter than DEB_CYCLES cycles are ignored. The counter restarts on any return to the stable level.
- Press event: the edge where stable goes 1->0.
  - On that same edge: step_out <= 1 and the capture below occurs. step_out <= 0 on all other edges, so exactly one cycle high.
  - Holding the key gives no repeat.
  - Release (stable 0->1) gives no step and no capture.
- Latency: key_n first sampled low at edge E0 and held low gives step_out high in the cycle after edge E0+DEB_CYCLES+1.
- Capture on press, mode=1 (data):
  - data_out[lane_idx*LANE_W +: LANE_W] <= ss[LANE_W-1:0]. Other lanes hold.
  - lane_idx <= lane_idx+1, wrapping LANES-1 -> 0.
  - ctrl_out holds.
- Capture on press, mode=0 (control):
  - ctrl_out <= ss[CTRL_W-1:0].
  - lane_idx <= 0.
  - data_out holds.
- Switch changes between presses have no effect on data_out or ctrl_out.
- Mode sampling: mode is the synced value on the press edge. Switches must be stable at least 2 cycles before the press completes.
- led_out (combinational from registers):
  - mode=1: ctrl_out.
  - mode=0: zero-extended data_out lane at lane_idx.
- LANES==1: lane_idx stays 0, and every data press overwrites the whole word.

Test Plan (DATA_W=16, LANE_W=8, CTRL_W=9, DEB_CYCLES=4):
1. Reset: hold reset_n=0 for 3 cycles with random sw/key_n -> data_out=0x0000, ctrl_out=0x000, lane_idx=0, step_out=0 throughout.
2. Data entry and wrap:
   - sw=10'h2A5, press 20 cycles -> one step pulse, data_out=0x00A5, lane_idx=1.
   - sw=10'h23C, press -> data_out=0x3CA5, lane_idx=0.
   - sw=10'h211, press -> data_out=0x3C11, lane_idx=1.
3. Bounce rejection: key_n low 3 cycles, high 2, low 3, then high -> no step pulse, all outputs unchanged.
4. Control entry:
   - sw=10'h0B5, press -> ctrl_out=0x0B5, lane_idx=0, data_out unchanged.
   - With mode=0, led_out=0x011 (lane 0 of 0x3C11).
   - Set sw=10'h2xx -> led_out=0x0B5.
5. Latency and hold: key_n low from edge E0 for 50 cycles -> step_out high only in the cycle after E0+5. No second pulse during hold or on release.
6. Reset mid-debounce: key_n low, reset_n=0 at E0+3 for one cycle, key_n still low -> no capture before reset. A step occurs 6 edges after reset deasserts, with the capture applied to the reset state (data press gives lane 0 written, lane_idx=1).

Source files
------------

// File: rtl/sw_step_iface.sv
// Board switch/key front end: synchronises and debounces a push-button into a
// one-cycle step pulse and captures control or lane data from the switches on that step.
module sw_step_iface #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned LANE_W     = 8,
   parameter int unsigned CTRL_W     = 9,
   parameter int unsigned DEB_CYCLES = 50000,
   localparam int unsigned LANES     = DATA_W / LANE_W,
   localparam int unsigned LIW       = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              key_n,
   input  logic [CTRL_W:0]   sw,
   output logic              step_out,
   output logic [DATA_W-1:0] data_out,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [LIW-1:0]    lane_idx,
   output logic [CTRL_W-1:0] led_out
);

   localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

   logic              key_s1, key_s2;
   logic [CTRL_W:0]   sw_s1, sw_s2;
   logic              stable;
   logic [CNT_W-1:0]  cnt;
   logic              mode;
   logic [LANE_W-1:0] lane_val;

   assign mode = sw_s2[CTRL_W];

   // Synchronisers, debounce counter, press detection and capture.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         key_s1   <= 1'b1;
         key_s2   <= 1'b1;
         sw_s1    <= '0;
         sw_s2    <= '0;
         stable   <= 1'b1;
         cnt      <= '0;
         step_out <= 1'b0;
         data_out <= '0;
         ctrl_out <= '0;
         lane_idx <= '0;
      end else begin
         key_s1   <= key_n;
         key_s2   <= key_s1;
         sw_s1    <= sw;
         sw_s2    <= sw_s1;
         step_out <= 1'b0;
         if (key_s2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            stable <= key_s2;
            cnt    <= '0;
            // key_s2 differs from stable, so a low level here is a 1->0 press
            if (!key_s2) begin
               step_out <= 1'b1;
               if (mode) begin
                  for (int unsigned i = 0; i < LANES; i++) begin
                     if (lane_idx == LIW'(i))
                        data_out[i*LANE_W +: LANE_W] <= sw_s2[LANE_W-1:0];
                  end
                  lane_idx <= (lane_idx == LIW'(LANES - 1)) ? '0 : lane_idx + LIW'(1);
               end else begin
                  ctrl_out <= sw_s2[CTRL_W-1:0];
                  lane_idx <= '0;
               end
            end
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Status display: control word while entering data, current lane otherwise.
   always_comb begin
      lane_val = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (lane_idx == LIW'(i))
            lane_val = data_out[i*LANE_W +: LANE_W];
      end
      led_out = mode ? ctrl_out : CTRL_W'(lane_val);
   end

endmodule

// File: tb/tb_sw_step_iface.sv
// Randomised self-checking bench for sw_step_iface against a behavioural
// model of the switch/key interface (synced-sample window debounce, lane array).
module tb_sw_step_iface;

   localparam int DEB = 4;

   logic        clk;
   logic        reset_n;
   logic        key_n;
   logic [9:0]  sw;
   logic        step_out;
   logic [15:0] data_out;
   logic [8:0]  ctrl_out;
   logic [0:0]  lane_idx;
   logic [8:0]  led_out;

   sw_step_iface #(.DATA_W(16), .LANE_W(8), .CTRL_W(9), .DEB_CYCLES(DEB)) dut (
      .clk(clk), .reset_n(reset_n), .key_n(key_n), .sw(sw),
      .step_out(step_out), .data_out(data_out), .ctrl_out(ctrl_out),
      .lane_idx(lane_idx), .led_out(led_out)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic       m_k1, m_k2;
   logic [9:0] m_s1, m_s2;
   logic       hist[$];
   logic       m_stable;
   logic [7:0] m_lanes[2];
   logic [8:0] m_ctrl;
   int         m_lane;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int act_steps = 0;
   int exp_steps = 0;
   int last_step_cyc = -1;

   function automatic logic [15:0] m_data();
      return {m_lanes[1], m_lanes[0]};
   endfunction

   function automatic logic [8:0] m_led();
      return m_s2[9] ? m_ctrl : {1'b0, m_lanes[m_lane]};
   endfunction

   // One clock edge: advance the model with the inputs present at the edge, observe step_out.
   task automatic tick();
      bit all_diff;
      @(posedge clk);
      if (!reset_n) begin
         m_k1 = 1'b1; m_k2 = 1'b1; m_s1 = '0; m_s2 = '0;
         hist.delete();
         m_stable = 1'b1;
         m_lanes[0] = '0; m_lanes[1] = '0;
         m_ctrl = '0; m_lane = 0;
      end else begin
         hist.push_back(m_k2);
         if (hist.size() > DEB) void'(hist.pop_front());
         all_diff = (hist.size() == DEB);
         foreach (hist[i]) if (hist[i] == m_stable) all_diff = 0;
         if (all_diff) begin
            m_stable = ~m_stable;
            hist.delete();
            if (!m_stable) begin
               exp_steps++;
               if (m_s2[9]) begin
                  m_lanes[m_lane] = m_s2[7:0];
                  m_lane = (m_lane + 1) % 2;
               end else begin
                  m_ctrl = m_s2[8:0];
                  m_lane = 0;
               end
            end
         end
         m_k2 = m_k1; m_k1 = key_n;
         m_s2 = m_s1; m_s1 = sw;
      end
      #1;
      cyc++;
      if (step_out === 1'b1) begin
         act_steps++;
         last_step_cyc = cyc;
      end
   endtask

   task automatic press(input logic [9:0] v, input int hold);
      sw = v;
      repeat (3) tick();
      key_n = 1'b0;
      repeat (hold) tick();
      key_n = 1'b1;
      repeat (8) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         key_n = 1'($urandom);
         sw = 10'($urandom);
         tick();
         n_checks++;
         if (data_out !== 16'h0000 || ctrl_out !== 9'h000 || lane_idx !== 1'b0 || step_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset[%0d]: got data=%h ctrl=%h lane=%0d step=%b want 0/0/0/0",
                     i, data_out, ctrl_out, lane_idx, step_out);
         end
      end
      reset_n = 1'b1;
      key_n = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_data_entry();
      int s0;
      logic [9:0] vals[3] = '{10'h2A5, 10'h23C, 10'h211};
      logic [15:0] exp_d[3] = '{16'h00A5, 16'h3CA5, 16'h3C11};
      logic [0:0] exp_l[3] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         s0 = act_steps;
         press(vals[i], 20);
         n_checks++;
         if (act_steps - s0 != 1) begin
            n_fail++;
            $display("FAIL data_pulses[%0d]: got %0d want 1", i, act_steps - s0);
         end
         n_checks++;
         if (data_out !== exp_d[i] || lane_idx !== exp_l[i] || ctrl_out !== 9'h000) begin
            n_fail++;
            $display("FAIL data_word[%0d]: got data=%h lane=%0d ctrl=%h want %h/%0d/000",
                     i, data_out, lane_idx, ctrl_out, exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_bounce();
      int s0;
      int runs[4] = '{3, 2, 3, 10};
      s0 = act_steps;
      for (int i = 0; i < 4; i++) begin
         key_n = 1'(i % 2);
         repeat (runs[i]) tick();
      end
      n_checks++;
      if (act_steps != s0 || data_out !== 16'h3C11 || lane_idx !== 1'b1 || ctrl_out !== 9'h000) begin
         n_fail++;
         $display("FAIL bounce: got pulses=%0d data=%h lane=%0d ctrl=%h want 0/3c11/1/000",
                  act_steps - s0, data_out, lane_idx, ctrl_out);
      end
   endtask

   task automatic test_control();
      press(10'h0B5, 20);
      n_checks++;
      if (ctrl_out !== 9'h0B5 || lane_idx !== 1'b0 || data_out !== 16'h3C11) begin
         n_fail++;
         $display("FAIL ctrl_capture: got ctrl=%h lane=%0d data=%h want 0b5/0/3c11",
                  ctrl_out, lane_idx, data_out);
      end
      n_checks++;
      if (led_out !== 9'h011) begin
         n_fail++;
         $display("FAIL led_mode0: got %h want 011", led_out);
      end
      sw = 10'h2FF;
      repeat (3) tick();
      n_checks++;
      if (led_out !== 9'h0B5 || ctrl_out !== 9'h0B5 || data_out !== 16'h3C11) begin
         n_fail++;
         $display("FAIL led_mode1: got led=%h ctrl=%h data=%h want 0b5/0b5/3c11",
                  led_out, ctrl_out, data_out);
      end
   endtask

   task automatic test_latency();
      int s0, t0;
      sw = 10'h25A;
      repeat (3) tick();
      s0 = act_steps;
      t0 = cyc;
      key_n = 1'b0;
      repeat (50) tick();
      key_n = 1'b1;
      repeat (20) tick();
      n_checks++;
      if (act_steps - s0 != 1 || last_step_cyc != t0 + 6) begin
         n_fail++;
         $display("FAIL latency: got pulses=%0d at cycle %0d want 1 at %0d",
                  act_steps - s0, last_step_cyc - t0, 6);
      end
      n_checks++;
      if (data_out !== m_data() || lane_idx !== 1'(m_lane)) begin
         n_fail++;
         $display("FAIL latency_capture: got data=%h lane=%0d want %h/%0d",
                  data_out, lane_idx, m_data(), m_lane);
      end
   endtask

   task automatic test_random();
      int s0, e0, len;
      s0 = act_steps;
      e0 = exp_steps;
      for (int r = 0; r < 80; r++) begin
         key_n = ~key_n;
         if ($urandom_range(0, 2) == 0) sw = 10'($urandom);
         len = $urandom_range(1, 7);
         repeat (len) tick();
      end
      key_n = 1'b1;
      repeat (10) tick();
      n_checks++;
      if (act_steps - s0 != exp_steps - e0) begin
         n_fail++;
         $display("FAIL random_pulses: got %0d want %0d", act_steps - s0, exp_steps - e0);
      end
      n_checks++;
      if (data_out !== m_data() || ctrl_out !== m_ctrl || lane_idx !== 1'(m_lane) || led_out !== m_led()) begin
         n_fail++;
         $display("FAIL random_state: got data=%h ctrl=%h lane=%0d led=%h want %h/%h/%0d/%h",
                  data_out, ctrl_out, lane_idx, led_out, m_data(), m_ctrl, m_lane, m_led());
      end
   endtask

   task automatic test_reset_mid();
      int s0, t0, r_cyc;
      key_n = 1'b1;
      sw = 10'h2C7;
      repeat (8) tick();
      s0 = act_steps;
      t0 = cyc;
      key_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b0;
      tick();
      r_cyc = cyc;
      reset_n = 1'b1;
      n_checks++;
      if (act_steps != s0 || data_out !== 16'h0000 || lane_idx !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_pre: got pulses=%0d data=%h lane=%0d want 0/0000/0",
                  act_steps - s0, data_out, lane_idx);
      end
      repeat (20) tick();
      n_checks++;
      if (act_steps - s0 != 1 || last_step_cyc != r_cyc + 6) begin
         n_fail++;
         $display("FAIL mid_reset_step: got pulses=%0d at +%0d want 1 at +6 (t0=%0d)",
                  act_steps - s0, last_step_cyc - r_cyc, t0);
      end
      n_checks++;
      if (data_out !== 16'h00C7 || lane_idx !== 1'b1 || ctrl_out !== 9'h000) begin
         n_fail++;
         $display("FAIL mid_reset_capture: got data=%h lane=%0d ctrl=%h want 00c7/1/000",
                  data_out, lane_idx, ctrl_out);
      end
      key_n = 1'b1;
      repeat (10) tick();
   endtask

   initial begin
      clk = 1'b0;
      reset_n = 1'b0;
      key_n = 1'b1;
      sw = '0;
      test_reset();
      test_data_entry();
      test_bounce();
      test_control();
      test_latency();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
